// File: rtl/trng_pkg.sv
// Shared types and default sizing for the TRNG collector.
// Optional repetition health test: TRNG_HEALTH_TEST_EN.
package trng_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        COLLECT = 2'd2,
        FULL    = 2'd3
    } trng_state_t;

    localparam int TRNG_WORD_WIDTH    = 32;
    localparam int TRNG_SAMPLE_DIV    = 4;
    localparam int TRNG_WARMUP_CYCLES = 64;
    localparam int TRNG_REP_LIMIT     = 32;

    // Counter width for a value range 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/trng_vn_debias.sv
// Von Neumann corrector: pairs raw samples, emits a bit for 01/10.
// The bit is combinational so it lands on the second sample's edge.
module trng_vn_debias (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic sample_stb,
    input  logic raw_bit,
    output logic bit_valid,
    output logic bit_out
);

    logic have_first;
    logic first_bit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            have_first <= 1'b0;
            first_bit  <= 1'b0;
        end else if (clear) begin
            have_first <= 1'b0;
            first_bit  <= 1'b0;
        end else if (sample_stb) begin
            have_first <= !have_first;
            if (!have_first)
                first_bit <= raw_bit;
        end
    end

    assign bit_valid = sample_stb && !clear && have_first
                       && (first_bit != raw_bit);
    assign bit_out   = first_bit;

endmodule

// File: rtl/trng_collector.sv
// TRNG consumer: warm-up, divided sampling, debias, word packing.
// Define TRNG_HEALTH_TEST_EN to add the repetition-count health test.
module trng_collector
    import trng_pkg::*;
#(
    parameter int WORD_WIDTH    = TRNG_WORD_WIDTH,
    parameter int SAMPLE_DIV    = TRNG_SAMPLE_DIV,
    parameter int WARMUP_CYCLES = TRNG_WARMUP_CYCLES,
    parameter int REP_LIMIT     = TRNG_REP_LIMIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    output logic                  trng_en,
    input  logic                  trng_bit,
    output logic [WORD_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  health_fail_o
);

    localparam int CW = $clog2(WORD_WIDTH + 1);
    localparam int DW = cnt_width(SAMPLE_DIV);
    localparam int WW = $clog2(WARMUP_CYCLES + 1);

    localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(WORD_WIDTH - 1);

    if (WORD_WIDTH < 2 || SAMPLE_DIV < 1 || WARMUP_CYCLES < 1
        || REP_LIMIT < 1) begin : g_param_check
        $error("trng_collector: illegal parameter value");
    end

    trng_state_t state;
    trng_state_t state_n;

    logic [DW-1:0]         div_q;
    logic [WW-1:0]         warm_q;
    logic [CW-1:0]         cnt_q;
    logic [WORD_WIDTH-2:0] shreg;
    logic [WORD_WIDTH-1:0] next_word;

    logic collecting;
    logic sample_stb;
    logic bit_valid;
    logic bit_out;
    logic word_done;
    logic xfer;
    logic health_hit;
    logic debias_clear;

    always_comb begin
        xfer       = valid_o && ready_i;
        collecting = (state == COLLECT) && enable;
        sample_stb = collecting && (div_q == DIV_LAST);
        word_done  = bit_valid && (cnt_q == CNT_LAST);
        next_word  = {shreg, bit_out};
    end

    assign debias_clear = !collecting || health_hit;

    trng_vn_debias u_debias (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (debias_clear),
        .sample_stb (sample_stb),
        .raw_bit    (trng_bit),
        .bit_valid  (bit_valid),
        .bit_out    (bit_out)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (enable)
                    state_n = WARMUP;
            end
            WARMUP: begin
                if (!enable)
                    state_n = IDLE;
                else if (warm_q == WARM_LAST)
                    state_n = COLLECT;
            end
            COLLECT: begin
                if (!enable)
                    state_n = IDLE;
                else if (word_done)
                    state_n = FULL;
            end
            FULL: begin
                if (xfer)
                    state_n = enable ? COLLECT : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            trng_en <= 1'b0;
            warm_q  <= '0;
            div_q   <= '0;
        end else begin
            state   <= state_n;
            trng_en <= (state_n != IDLE);
            if (state == WARMUP && enable && warm_q != WARM_LAST)
                warm_q <= warm_q + WW'(1);
            else
                warm_q <= '0;
            if (collecting && div_q != DIV_LAST)
                div_q <= div_q + DW'(1);
            else
                div_q <= '0;
        end
    end

    // Partial word is dropped whenever collection stops or health trips.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg   <= '0;
            cnt_q   <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
        end else begin
            if (!collecting || health_hit) begin
                shreg <= '0;
                cnt_q <= '0;
            end else if (bit_valid) begin
                shreg <= next_word[WORD_WIDTH-2:0];
                cnt_q <= word_done ? '0 : cnt_q + CW'(1);
            end
            if (word_done) begin
                data_o  <= next_word;
                valid_o <= 1'b1;
            end else if (xfer) begin
                valid_o <= 1'b0;
            end
        end
    end

    assign busy_o = (state == WARMUP) || (state == COLLECT);

`ifdef TRNG_HEALTH_TEST_EN
    localparam int RW = $clog2(REP_LIMIT + 1);
    localparam logic [RW-1:0] REP_MAX = RW'(REP_LIMIT);

    logic [RW-1:0] run_q;
    logic [RW-1:0] run_n;
    logic          last_q;
    logic          fail_q;

    always_comb begin
        run_n = RW'(1);
        if (run_q != '0 && trng_bit == last_q)
            run_n = (run_q == REP_MAX) ? run_q : run_q + RW'(1);
    end

    assign health_hit = sample_stb && (run_n == REP_MAX)
                        && (run_q != REP_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n || state == IDLE) begin
            run_q  <= '0;
            last_q <= 1'b0;
            fail_q <= 1'b0;
        end else if (sample_stb) begin
            run_q  <= run_n;
            last_q <= trng_bit;
            if (health_hit)
                fail_q <= 1'b1;
        end
    end

    assign health_fail_o = fail_q;
`else
    assign health_hit    = 1'b0;
    assign health_fail_o = 1'b0;
`endif

endmodule

// File: doc/trng_collector.md
Name: trng_collector

Overview:
Consumer end of the ring-oscillator TRNG. Drives the TRNG enable and samples its raw output bit at a programmable rate. Removes bias with a von Neumann corrector, packs the corrected bits into WORD_WIDTH-bit words, and offers each word to the SoC bus over a valid/ready handshake. Sits between the trng_NxM oscillator configuration and the peripheral register interface.

Parameters:
WORD_WIDTH, 32, width of delivered random word (must be ≥2)
SAMPLE_DIV, 4, clocks per raw sample (≥1; 1 = sample every clock)
WARMUP_CYCLES, 64, clocks after enable before the first sample is taken (≥1)
REP_LIMIT, 32, consecutive identical raw samples that flag a health failure (optional feature only)

Ports:
clk  input  1  system clock; also the TRNG sampling clock
rst_n  input  1  synchronous reset, active-low
enable  input  1  request collection
trng_en  output  1  enable to the oscillator array
trng_bit  input  1  raw TRNG output; already synchronous to clk
data_o  output  WORD_WIDTH  completed random word
valid_o  output  1  data_o holds an unread word
ready_i  input  1  consumer accepts data_o
busy_o  output  1  state is WARMUP or COLLECT
health_fail_o  output  1  sticky repetition-count failure

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE. trng_en=0, data_o=0, valid_o=0, busy_o=0, health_fail_o=0. Divider, warm-up counter, pair register and bit count all 0.
- FSM states:
  - IDLE: trng_en=0. Goes to WARMUP when enable=1.
  - WARMUP: trng_en=1. Counts WARMUP_CYCLES clocks, then goes to COLLECT with divider=0.
  - COLLECT: trng_en=1. Divider counts 0..SAMPLE_DIV-1; trng_bit is sampled on the clock where divider==SAMPLE_DIV-1.
  - FULL: trng_en=1. Sampling is stalled; waits for the handshake.
- trng_en is a registered output equal to (state != IDLE).
- Von Neumann correction: raw samples are paired as first and second.
  - 01 → corrected bit 0.
  - 10 → corrected bit 1.
  - 00 and 11 → pair discarded.
  - Pairs never overlap.
- Packing:
  - Each corrected bit is shifted in at the LSB, shifting left, so the first bit of a word ends at the MSB.
  - The bit count is $clog2(WORD_WIDTH+1) bits wide.
  - On the edge that accepts the WORD_WIDTH-th bit: data_o is loaded with the full word, valid_o=1, count=0, state goes to FULL. The bit is registered on the same edge as the second sample of its pair, so there are no extra cycles of latency.
- Handshake:
  - A transfer occurs on any edge where valid_o && ready_i; valid_o then drops the next cycle.
  - data_o and valid_o stay stable while valid_o=1 && !ready_i.
  - From FULL with a transfer: go to COLLECT if enable=1, else IDLE.
  - ready_i has no effect while valid_o=0.
- enable deasserted in WARMUP or COLLECT:
  - Next state is IDLE; the partial word, pair register and divider are discarded.
  - A pending valid word stays valid until it is transferred.
  - Re-enabling always re-runs WARMUP.
- enable deasserted in FULL: the state stays FULL until the transfer, then goes to IDLE.
- rst_n low at any time overrides everything, including a pending valid word, which is lost.
- busy_o = (state==WARMUP || state==COLLECT).

Optional Feature:
TRNG_HEALTH_TEST_EN
- Defined:
  - Tracks the run length of identical raw samples, saturating at REP_LIMIT.
  - When the run reaches REP_LIMIT: health_fail_o=1 (sticky), the partial word and pair register are discarded, and collection continues.
  - health_fail_o is cleared only by reset or by state IDLE. The run counter also clears in IDLE.
- Undefined: health_fail_o is tied to 0 and no counter logic is present. The port always exists.

Decomposition:
- Package trng_pkg holds:
  - the state enum trng_state_t {IDLE, WARMUP, COLLECT, FULL};
  - default constants TRNG_WORD_WIDTH=32, TRNG_SAMPLE_DIV=4, TRNG_WARMUP_CYCLES=64, TRNG_REP_LIMIT=32.
- One sub-module, trng_vn_debias:
  - inputs: clk, rst_n, clear, sample_stb, raw_bit;
  - outputs: bit_valid, bit_out;
  - owns the pair register.
- trng_collector instantiates trng_vn_debias and the oscillator wrapper is external.

Test Plan (WORD_WIDTH=8, SAMPLE_DIV=1, WARMUP_CYCLES=4, REP_LIMIT=8 unless stated):
- Reset then enable=1: trng_en=1 one cycle later; first sample taken after 4 warm-up clocks; busy_o=1 throughout.
- Raw stream 10,01,10,10,01,01,10,01 with ready_i=0 → data_o=8'hB2 (1011_0010), valid_o=1, state FULL. trng_bit is ignored until ready_i=1; then valid_o=0 the next cycle and collection resumes.
- Raw stream 00,11,00,10 ×8 → 00/11 pairs are discarded and the word is 8'hFF. Same test with SAMPLE_DIV=4: the first word arrives 4× later (in cycles).
- enable dropped after 5 corrected bits → IDLE, trng_en=0. Re-enabling runs WARMUP, then 8 new bits form a fresh word; none of the 5 old bits appear.
- Word pending with ready_i=0 and enable dropped → valid_o and data_o are held stable; the transfer completes with ready_i=1, then the state is IDLE.
- With TRNG_HEALTH_TEST_EN: stuck trng_bit=1 for 8 samples → health_fail_o=1, partial word discarded. Bit stays set until enable=0 for one cycle; without the macro the bit stays 0.
